// File: rtl/reg_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// reg_writeback_arbiter_pkg : shared constants for the writeback arbiter
// Revision : 1.0
// ============================================================================
package reg_writeback_arbiter_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;
endpackage
`default_nettype wire

// File: rtl/reg_writeback_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// wb_scoreboard : pending-write bit per register with same-edge set priority
// Revision : 1.0
// ============================================================================
module wb_scoreboard
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int A_W  = ADDR_W,
  parameter int N_R  = NUM_REGS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_en,
  input  logic [A_W-1:0] clr_addr,
  input  logic           set_en,
  input  logic [A_W-1:0] set_addr,
  input  logic [A_W-1:0] rs1,
  input  logic [A_W-1:0] rs2,
  output logic           rs1_busy,
  output logic           rs2_busy
);

  logic [N_R-1:0] pending_q;
  logic [N_R-1:0] pending_d;

  generate
    for (genvar i = 0; i < N_R; i++) begin : g_pending
      if (i == 0) begin : g_zero
        assign pending_d[i] = 1'b0;
      end else begin : g_reg
        // A new producer issued on the commit edge keeps the register busy.
        assign pending_d[i] = (set_en && (set_addr == A_W'(i))) ? 1'b1 :
                              (clr_en && (clr_addr == A_W'(i))) ? 1'b0 :
                              pending_q[i];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy = pending_q[rs1];
  assign rs2_busy = pending_q[rs2];

endmodule
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// reg_writeback_arbiter : ALU/load writeback arbitration, output register and
//                         RAW hazard scoreboard for the 16x16 register file
// Revision : 1.0
// ============================================================================
module reg_writeback_arbiter #(
  parameter int DATA_W       = reg_writeback_arbiter_pkg::DATA_W,
  parameter int ADDR_W       = reg_writeback_arbiter_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_itype
);
  import reg_writeback_arbiter_pkg::REG_ZERO;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic alu_force;
  logic alu_acc;
  logic mem_acc;

  always_comb begin
    alu_force    = (starve_cnt_q == CNT_MAX);
    mem_ready    = !alu_force || !alu_valid;
    alu_ready    = !mem_valid || alu_force;
    alu_acc      = alu_valid && alu_ready;
    mem_acc      = mem_valid && mem_ready && !alu_acc;

    starve_cnt_d = '0;
    if (alu_valid && !alu_ready) begin
      starve_cnt_d = alu_force ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    // r0 writes still take the slot, they just never reach the register file.
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_acc) begin
      wr_en_d   = (alu_rd != ADDR_W'(REG_ZERO));
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (mem_acc) begin
      wr_en_d   = (mem_rd != ADDR_W'(REG_ZERO));
      wr_addr_d = mem_rd;
      wr_data_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  wb_scoreboard #(
    .A_W (ADDR_W),
    .N_R (1 << ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (wr_en_q),
    .clr_addr (wr_addr_q),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  assign stall    = rs1_busy | rs2_busy;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_itype = 1'b0;

endmodule
`default_nettype wire
